// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch update tracker in front of the
// 2-bit saturating branch predictor.
package bp_pkg;

    localparam int BP_DEPTH_DEF = 4;
    localparam int BP_CNT_W_DEF = 16;

    // One outstanding branch: filled is set once the predictor's answer lands.
    typedef struct packed {
        logic filled;
        logic pred;
    } bp_entry_t;

endpackage

// File: rtl/bp_pred_fifo.sv
// In-order store of outstanding branch predictions. A slot is reserved at
// fetch and filled one cycle later, when the predictor answers.
module bp_pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             reserve,
    input  logic             fill,
    input  logic             fill_pred,
    input  logic             pop,
    output logic [PTR_W:0]   count,
    output bp_entry_t        head,
    output logic             empty
);

    bp_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] fill_idx;

    // The tail has already moved past the slot reserved last cycle.
    assign fill_idx = tail_ptr - 1'b1;
    assign head     = mem[head_ptr];
    assign empty    = (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (reserve) begin
                mem[tail_ptr] <= '0;
                tail_ptr      <= tail_ptr + 1'b1;
            end
            if (fill) begin
                mem[fill_idx] <= '{filled: 1'b1, pred: fill_pred};
            end
            // A pop only ever targets a filled head, so it never meets the fill slot.
            if (pop) begin
                mem[head_ptr].filled <= 1'b0;
                head_ptr             <= head_ptr + 1'b1;
            end
            case ({reserve, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_update_tracker.sv
// Issues predictor lookups for fetched branches, matches predictions to
// in-order resolutions, flags mispredicts and schedules predictor training.
module branch_update_tracker
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = BP_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    output logic             fetch_pred_valid,
    output logic             fetch_pred,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             resolve_ready,
    output logic             request,
    input  logic             prediction,
    output logic             result,
    output logic             taken,
    output logic             mispredict_valid,
    output logic             mispredict,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && !(&v)) ? v + 1'b1 : v;
    endfunction

    logic [PTR_W:0]   count;
    bp_entry_t        head;
    logic             empty;
    logic             full;
    logic             resolve_fire;
    logic             mis_now;

    logic             cap_pend_p1;
    logic             upd_pend;
    logic             upd_taken;
    logic             vld_p1;
    logic             mis_p1;
    logic [CNT_W-1:0] resolved_q;
    logic [CNT_W-1:0] mispred_q;

    assign full          = (count == FULL_CNT);
    assign fetch_ready   = !full && !flush;
    assign request       = fetch_valid && fetch_ready;
    // A resolved branch must train before the next one may resolve.
    assign resolve_ready = !empty && head.filled && !upd_pend && !flush;
    assign resolve_fire  = resolve_valid && resolve_ready;
    assign mis_now       = head.pred != resolve_taken;

    // The predictor ignores result while request is high, so lookups win.
    assign result           = upd_pend && !request;
    assign taken            = upd_taken;
    assign fetch_pred_valid = cap_pend_p1;
    assign fetch_pred       = prediction;
    assign mispredict_valid = vld_p1;
    assign mispredict       = mis_p1;
    assign resolved_cnt     = resolved_q;
    assign mispred_cnt      = mispred_q;

    bp_pred_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .reserve   (request),
        .fill      (cap_pend_p1),
        .fill_pred (prediction),
        .pop       (resolve_fire),
        .count     (count),
        .head      (head),
        .empty     (empty)
    );

    // p0 -> p1: lookup capture, resolve outcome and statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_pend_p1 <= 1'b0;
            upd_pend    <= 1'b0;
            upd_taken   <= 1'b0;
            vld_p1      <= 1'b0;
            mis_p1      <= 1'b0;
            resolved_q  <= '0;
            mispred_q   <= '0;
        end else begin
            cap_pend_p1 <= request && !flush;
            if (resolve_fire) begin
                upd_pend  <= 1'b1;
                upd_taken <= resolve_taken;
            end else if (result) begin
                upd_pend  <= 1'b0;
            end
            vld_p1 <= resolve_fire;
            if (resolve_fire) mis_p1 <= mis_now;
            resolved_q <= sat_inc(resolved_q, resolve_fire);
            mispred_q  <= sat_inc(mispred_q, resolve_fire && mis_now);
        end
    end

endmodule

// File: tb/tb_branch_update_tracker.sv
// Scoreboard bench for branch_update_tracker: a cycle model predicts every
// handshake output, queued predictions and queued mispredict outcomes.
module tb_branch_update_tracker;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset, flush, fetch_valid, resolve_valid, resolve_taken, prediction;
    logic fetch_ready, fetch_pred_valid, fetch_pred, resolve_ready, request;
    logic result, taken, mispredict_valid, mispredict;
    logic [CNT_W-1:0] resolved_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_update_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_pred_valid (fetch_pred_valid),
        .fetch_pred       (fetch_pred),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_ready    (resolve_ready),
        .request          (request),
        .prediction       (prediction),
        .result           (result),
        .taken            (taken),
        .mispredict_valid (mispredict_valid),
        .mispredict       (mispredict),
        .resolved_cnt     (resolved_cnt),
        .mispred_cnt      (mispred_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        bit filled;
        bit pred;
    } ent_t;

    ent_t mq[$];
    bit   exp_pred_q[$];
    bit   exp_mis_q[$];
    bit   m_cap, m_upd, m_updt, m_misv;
    int   m_res, m_mis;
    bit   pred_tab[256];
    int   fetch_idx = 0;
    bit   pred_nxt = 1'b0;

    // Model evaluated mid-cycle: check outputs, then advance to the next edge.
    always @(negedge clk) begin
        bit e_fready, e_req, e_rready, e_result, fire_res, b;
        ent_t e;
        if (reset) begin
            mq.delete();
            exp_pred_q.delete();
            exp_mis_q.delete();
            m_cap = 0; m_upd = 0; m_updt = 0; m_misv = 0;
            m_res = 0; m_mis = 0;
        end else begin
            e_fready = (mq.size() < DEPTH) && !flush;
            e_req    = fetch_valid && e_fready;
            e_rready = (mq.size() > 0) && mq[0].filled && !m_upd && !flush;
            e_result = m_upd && !e_req;
            fire_res = resolve_valid && e_rready;

            chk("fetch_ready", 32'(fetch_ready), 32'(e_fready));
            chk("request", 32'(request), 32'(e_req));
            chk("resolve_ready", 32'(resolve_ready), 32'(e_rready));
            chk("result", 32'(result), 32'(e_result));
            chk("taken", 32'(taken), 32'(m_updt));
            chk("fetch_pred_valid", 32'(fetch_pred_valid), 32'(m_cap));
            chk("mispredict_valid", 32'(mispredict_valid), 32'(m_misv));
            chk("resolved_cnt", 32'(resolved_cnt), 32'(m_res));
            chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mis));
            chk("count", 32'(dut.u_fifo.count), 32'(mq.size()));
            if (fetch_pred_valid === 1'b1) begin
                if (exp_pred_q.size() == 0) chk("fetch_pred_unexpected", 1, 0);
                else begin
                    b = exp_pred_q.pop_front();
                    chk("fetch_pred", 32'(fetch_pred), 32'(b));
                end
            end
            if (mispredict_valid === 1'b1) begin
                if (exp_mis_q.size() == 0) chk("mispredict_unexpected", 1, 0);
                else begin
                    b = exp_mis_q.pop_front();
                    chk("mispredict", 32'(mispredict), 32'(b));
                end
            end

            if (flush) begin
                mq.delete();
            end else begin
                if (m_cap && mq.size() > 0) begin
                    e = mq[mq.size()-1];
                    e.filled = 1;
                    e.pred   = prediction;
                    mq[mq.size()-1] = e;
                end
                if (fire_res) begin
                    e = mq.pop_front();
                    exp_mis_q.push_back(e.pred != resolve_taken);
                    if (m_res < MAXC) m_res++;
                    if (e.pred != resolve_taken && m_mis < MAXC) m_mis++;
                end
                if (e_req) mq.push_back('{filled: 0, pred: 0});
            end
            m_cap = e_req;
            if (e_req) begin
                pred_nxt = pred_tab[fetch_idx % 256];
                exp_pred_q.push_back(pred_nxt);
                fetch_idx++;
            end else begin
                pred_nxt = 1'($urandom);
            end
            if (fire_res) begin
                m_upd  = 1;
                m_updt = resolve_taken;
            end else if (e_result) begin
                m_upd = 0;
            end
            m_misv = fire_res;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        prediction = pred_nxt;
    endtask

    task automatic drive(input bit fv, input bit rv, input bit rt, input bit fl);
        fetch_valid   = fv;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
    endtask

    task automatic cyc(input bit fv, input bit rv, input bit rt, input bit fl);
        drive(fv, rv, rt, fl);
        tick();
    endtask

    task automatic resolve_one(input bit rt);
        bit fired = 0;
        drive(0, 1, rt, 0);
        for (int i = 0; i < 20 && !fired; i++) begin
            #1;
            fired = resolve_ready;
            tick();
        end
        drive(0, 0, 0, 0);
        if (!fired) chk("resolve_timeout", 0, 1);
    endtask

    initial begin
        pred_tab[0] = 1; pred_tab[1] = 0; pred_tab[2] = 1;
        for (int i = 3; i < 256; i++) pred_tab[i] = 1'($urandom);
        reset = 1;
        prediction = 0;
        drive(0, 0, 0, 0);
        tick(); tick();
        chk("rst_fetch_ready", 32'(fetch_ready), 1);
        chk("rst_result", 32'(result), 0);
        chk("rst_mispredict_valid", 32'(mispredict_valid), 0);
        chk("rst_resolve_ready", 32'(resolve_ready), 0);
        reset = 0;
        tick();

        // Three lookups, then fill the queue and push against full.
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("three_count", 32'(dut.u_fifo.count), 3);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("full_no_request", 32'(request), 0);

        // Head predicted taken, actual not taken.
        resolve_one(0);
        #1;
        chk("mis_valid", 32'(mispredict_valid), 1);
        chk("mis_bit", 32'(mispredict), 1);
        chk("mis_result", 32'(result), 1);
        chk("mis_taken", 32'(taken), 0);
        tick();

        // Drain, then hold off training with a continuous fetch stream.
        resolve_one(1); cyc(0, 0, 0, 0);
        resolve_one(1); cyc(0, 0, 0, 0);
        resolve_one(0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

        // Flush with entries outstanding, capture pending and training pending.
        resolve_one(1);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 1);
        #1;
        chk("flush_count", 32'(dut.u_fifo.count), 0);
        chk("flush_no_pred", 32'(fetch_pred_valid), 0);
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 3) != 0, 1'($urandom), 1'($urandom), ($urandom % 40) == 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1'($urandom), 0);

        // Enough resolves to saturate the narrow statistics counters.
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
            resolve_one(1'($urandom));
            cyc(0, 0, 0, 0);
        end
        chk("resolved_sat", 32'(resolved_cnt), 32'(MAXC));

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        #2;
        reset = 1;
        #1;
        chk("arst_fetch_ready", 32'(fetch_ready), 1);
        chk("arst_result", 32'(result), 0);
        chk("arst_mispredict_valid", 32'(mispredict_valid), 0);
        chk("arst_fetch_pred_valid", 32'(fetch_pred_valid), 0);
        chk("arst_resolve_ready", 32'(resolve_ready), 0);
        chk("arst_resolved_cnt", 32'(resolved_cnt), 0);
        chk("arst_mispred_cnt", 32'(mispred_cnt), 0);
        tick();
        reset = 0;
        cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
